// File: rtl/conv_1st_ctrl_if.sv
// rtl/conv_1st_ctrl_if.sv - control, buffer-read, array and row-output signals of conv_1st_ctrl
interface conv_1st_ctrl_if #(
    parameter int ADDR_W = 5
);
    logic              start;
    logic              busy;
    logic              done;
    logic              pix_rd_en;
    logic [ADDR_W-1:0] pix_rd_addr;
    logic              wgt_rd_en;
    logic [ADDR_W-1:0] wgt_rd_addr;
    logic              array_en;
    logic              array_flush;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_row;

    modport master (
        input  start, out_ready,
        output busy, done, pix_rd_en, pix_rd_addr, wgt_rd_en, wgt_rd_addr,
               array_en, array_flush, out_valid, out_row
    );

    modport slave (
        output start, out_ready,
        input  busy, done, pix_rd_en, pix_rd_addr, wgt_rd_en, wgt_rd_addr,
               array_en, array_flush, out_valid, out_row
    );
endinterface

// File: rtl/conv_1st_ctrl.sv
// rtl/conv_1st_ctrl.sv - first-layer conv systolic array sequencer; optional abort via CONV1ST_CTRL_ABORT_EN
module conv_1st_ctrl #(
    parameter int KH       = 11,
    parameter int OUT_ROWS = 20,
    parameter int RD_LAT   = 1,
    parameter int ADDR_W   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef CONV1ST_CTRL_ABORT_EN
    input  logic            abort,
`endif
    conv_1st_ctrl_if.master bus
);
    localparam int                WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(KH - 1);
    localparam logic [ADDR_W-1:0] R_LAST = ADDR_W'(OUT_ROWS - 1);
    localparam logic [WAIT_W-1:0] W_LAST = WAIT_W'(RD_LAT - 1);

    typedef enum logic [2:0] {IDLE, FLUSH, ACC, WAIT, OUT, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] r;
    logic [ADDR_W-1:0] k;
    logic [WAIT_W-1:0] wcnt;
    logic [RD_LAT-1:0] en_dly;

    // Last delay stage is the array enable, so en lands with the read data.
    assign bus.array_en = en_dly[RD_LAT-1];

    // Outputs are registered alongside the state: each branch sets what the next state shows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            r               <= '0;
            k               <= '0;
            wcnt            <= '0;
            en_dly          <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.pix_rd_en   <= 1'b0;
            bus.pix_rd_addr <= '0;
            bus.wgt_rd_en   <= 1'b0;
            bus.wgt_rd_addr <= '0;
            bus.array_flush <= 1'b0;
            bus.out_valid   <= 1'b0;
            bus.out_row     <= '0;
        end else begin
            bus.busy        <= 1'b1;
            bus.done        <= 1'b0;
            bus.pix_rd_en   <= 1'b0;
            bus.wgt_rd_en   <= 1'b0;
            bus.array_flush <= 1'b0;
            bus.out_valid   <= 1'b0;

            en_dly[0] <= bus.pix_rd_en;
            for (int i = 1; i < RD_LAT; i++) begin
                en_dly[i] <= en_dly[i-1];
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state           <= FLUSH;
                        r               <= '0;
                        bus.array_flush <= 1'b1;
                    end else begin
                        bus.busy <= 1'b0;
                    end
                end
                FLUSH: begin
                    state           <= ACC;
                    k               <= '0;
                    bus.pix_rd_en   <= 1'b1;
                    bus.wgt_rd_en   <= 1'b1;
                    bus.pix_rd_addr <= r;
                    bus.wgt_rd_addr <= '0;
                end
                ACC: begin
                    if (k == K_LAST) begin
                        state <= WAIT;
                        wcnt  <= '0;
                    end else begin
                        k               <= k + ADDR_W'(1);
                        bus.pix_rd_en   <= 1'b1;
                        bus.wgt_rd_en   <= 1'b1;
                        bus.pix_rd_addr <= r + k + ADDR_W'(1);
                        bus.wgt_rd_addr <= k + ADDR_W'(1);
                    end
                end
                WAIT: begin
                    if (wcnt == W_LAST) begin
                        state         <= OUT;
                        bus.out_valid <= 1'b1;
                        bus.out_row   <= r;
                    end else begin
                        wcnt <= wcnt + WAIT_W'(1);
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        if (r == R_LAST) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end else begin
                            r               <= r + ADDR_W'(1);
                            state           <= FLUSH;
                            bus.array_flush <= 1'b1;
                        end
                    end else begin
                        bus.out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase

`ifdef CONV1ST_CTRL_ABORT_EN
            // Abort wins over everything above: one clearing flush, then idle.
            if (abort && state != IDLE) begin
                state           <= IDLE;
                en_dly          <= '0;
                bus.busy        <= 1'b0;
                bus.done        <= 1'b0;
                bus.pix_rd_en   <= 1'b0;
                bus.wgt_rd_en   <= 1'b0;
                bus.out_valid   <= 1'b0;
                bus.array_flush <= 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_conv_1st_ctrl.sv
// tb/tb_conv_1st_ctrl.sv - directed self-checking bench for conv_1st_ctrl
module tb_conv_1st_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
`ifdef CONV1ST_CTRL_ABORT_EN
    logic abort = 1'b0;
`endif
    int checks = 0;
    int errors = 0;

    conv_1st_ctrl_if #(.ADDR_W(5)) bus ();

    conv_1st_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef CONV1ST_CTRL_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {bus.busy, bus.done, bus.pix_rd_en, bus.wgt_rd_en, bus.array_en,
                  bus.array_flush, bus.out_valid, bus.out_row}, 32'h0);
    endtask

    // Full frame with out_ready high: 14-cycle rows (flush, 11 acc, wait, out), done at t=281.
    task automatic frame_check(input string tag);
        int beats = 0;
        int max_addr = 0;
        int row, p;
        logic [6:0] exp_v, obs_v;
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int t = 1; t <= 281; t++) begin
            if (t == 100) bus.start = 1'b1;
            if (t == 101) bus.start = 1'b0;
            row = (t - 1) / 14;
            p   = (t - 1) % 14;
            exp_v = {1'b1, t == 281, (t < 281 && p == 0),
                     (t < 281 && p >= 1 && p <= 11), (t < 281 && p >= 1 && p <= 11),
                     (t < 281 && p >= 2 && p <= 12), (t < 281 && p == 13)};
            obs_v = {bus.busy, bus.done, bus.array_flush, bus.pix_rd_en, bus.wgt_rd_en,
                     bus.array_en, bus.out_valid};
            chk($sformatf("%s ctl t=%0d", tag, t), 32'(obs_v), 32'(exp_v));
            if (exp_v[3]) begin
                chk($sformatf("%s pix_addr t=%0d", tag, t), 32'(bus.pix_rd_addr), 32'(row + p - 1));
                chk($sformatf("%s wgt_addr t=%0d", tag, t), 32'(bus.wgt_rd_addr), 32'(p - 1));
            end
            if (bus.pix_rd_en && int'(bus.pix_rd_addr) > max_addr) max_addr = int'(bus.pix_rd_addr);
            if (exp_v[0]) begin
                chk($sformatf("%s out_row t=%0d", tag, t), 32'(bus.out_row), 32'(row));
            end
            if (bus.out_valid && bus.out_ready) beats++;
            if (t < 281) @(negedge clk);
        end
        chk({tag, " beats"}, 32'(beats), 32'd20);
        chk({tag, " max_pix_addr"}, 32'(max_addr), 32'd29);
    endtask

    initial begin
        int cnt;
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset_outputs");
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("idle_after_reset");

        // Full frame, with a mid-frame start pulse inside frame_check.
        frame_check("frame1");

        // Start pulsed on the done cycle is ignored.
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_done", 32'(bus.busy), 32'd0);
        chk("no_flush_after_done", 32'(bus.array_flush), 32'd0);
        repeat (3) @(negedge clk);
        chk("still_idle", 32'({bus.busy, bus.array_flush, bus.pix_rd_en}), 32'd0);

        // Backpressure at row 7 for 50 cycles.
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (111) @(negedge clk);
        chk("row7_valid", 32'(bus.out_valid), 32'd1);
        chk("row7_row", 32'(bus.out_row), 32'd7);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 50; i++) begin
            chk($sformatf("hold%0d", i),
                32'({bus.out_valid, bus.out_row, bus.array_en, bus.pix_rd_en, bus.wgt_rd_en, bus.busy}),
                32'({1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1}));
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("row8_flush", 32'({bus.array_flush, bus.out_valid}), 32'b10);
        cnt = 0;
        while (!bus.done && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        chk("done_after_hold", 32'(bus.done), 32'd1);
        chk("rest_of_frame_len", 32'(cnt), 32'd168);
        @(negedge clk);

        // Asynchronous reset during row 5 ACC.
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (74) @(negedge clk);
        chk("row5_acc_addr", 32'({bus.pix_rd_en, bus.pix_rd_addr}), 32'({1'b1, 5'd8}));
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        frame_check("frame_after_reset");
        @(negedge clk);

`ifdef CONV1ST_CTRL_ABORT_EN
        // Abort in WAIT of row 2.
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (40) @(negedge clk);
        chk("row2_wait", 32'({bus.array_en, bus.pix_rd_en, bus.out_valid}), 32'b100);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_flush", 32'({bus.array_flush, bus.busy, bus.pix_rd_en, bus.array_en, bus.out_valid}),
            32'b10000);
        @(negedge clk);
        chk("abort_idle", 32'({bus.array_flush, bus.busy}), 32'b00);
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            if (bus.done || bus.busy) cnt++;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(cnt), 32'd0);
        frame_check("frame_after_abort");
        @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
